// File: rtl/ripple_sum_accumulator.sv
// Accumulates bursts of N_SAMPLES 5-bit {Co,S} adder results into an ACC_W-bit total
// with a sticky overflow flag, using valid/ready handshakes on both sides.
module ripple_sum_accumulator #(
    parameter int ACC_W     = 8,
    parameter int N_SAMPLES = 16,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       S,
    input  logic             Co,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    // Handshake rule (both ports): a transfer happens on a rising edge where
    // valid and ready are both high; ready/valid driven here depend only on state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [ACC_W-1:0] sample;
    logic [ACC_W:0]   sum;
    logic             take;
    logic             last;

    assign sample = ACC_W'({Co, S});
    assign sum    = {1'b0, acc_out} + {1'b0, sample};
    assign take   = in_valid && (state == ACCUM);
    assign last   = (count == LAST_IDX);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)        state_next = ACCUM;
            ACCUM:   if (take && last) state_next = DONE;
            DONE:    if (out_ready)    state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The total and flag survive the return to IDLE and are cleared only by a new start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_out  <= '0;
            overflow <= 1'b0;
            count    <= '0;
        end else if (state == IDLE && start) begin
            acc_out  <= '0;
            overflow <= 1'b0;
            count    <= '0;
        end else if (take) begin
            acc_out  <= sum[ACC_W-1:0];
            overflow <= overflow | sum[ACC_W];
            count    <= count + CNT_W'(1);
        end
    end

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_ripple_sum_accumulator.sv
// Randomised bench for ripple_sum_accumulator; expected totals come from plain
// integer sums of the samples sent in each burst.
module tb_ripple_sum_accumulator;

    localparam int ACC_W     = 8;
    localparam int N_SAMPLES = 16;
    localparam int CNT_W     = 4;
    localparam int BUDGET    = 2000;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [3:0]       s;
    logic             co;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] acc_out;
    logic             out_valid;
    logic             out_ready;
    logic             overflow;
    logic             busy;
    logic [1:0]       dbg_state;

    int vectors;
    int miscompares;

    logic [4:0]       stim_q[$];
    logic [ACC_W-1:0] exp_q[$];

    ripple_sum_accumulator #(
        .ACC_W(ACC_W), .N_SAMPLES(N_SAMPLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .S(s), .Co(co),
        .in_valid(in_valid), .in_ready(in_ready), .acc_out(acc_out),
        .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow),
        .busy(busy), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the burst total is the integer sum of its samples.
    function automatic int model_total();
        int t = 0;
        foreach (stim_q[i]) t += int'(stim_q[i]);
        return t;
    endfunction

    task automatic fill_const(input logic [4:0] v);
        stim_q.delete();
        for (int i = 0; i < N_SAMPLES; i++) stim_q.push_back(v);
    endtask

    task automatic fill_random();
        stim_q.delete();
        for (int i = 0; i < N_SAMPLES; i++) stim_q.push_back(5'($urandom_range(0, 31)));
    endtask

    task automatic issue_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode 0: valid always, 1: valid every other cycle, 2: random valid
    task automatic feed_samples(input int mode, output int cycles, output int ready_cycles,
                                output bit timed_out);
        int idx;
        bit hs;
        idx = 0; cycles = 0; ready_cycles = 0; timed_out = 0;
        while (idx < N_SAMPLES) begin
            if (cycles >= BUDGET) begin
                timed_out = 1;
                break;
            end
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (cycles % 2 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            {co, s} = stim_q[idx];
            hs = in_valid && in_ready;
            if (in_ready) ready_cycles++;
            @(posedge clk); #1;
            cycles++;
            if (hs) idx++;
        end
        in_valid = 1'b0;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({acc_out, overflow, in_ready, out_valid, busy, dbg_state} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: acc=%h ovf=%b rdy=%b ov=%b busy=%b st=%0d, all zero required",
                     acc_out, overflow, in_ready, out_valid, busy, dbg_state);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_burst();
        issue_start();
        {co, s} = 5'b11111;
        in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({acc_out, overflow, in_ready, out_valid, busy, dbg_state} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_burst: acc=%h ovf=%b rdy=%b ov=%b busy=%b st=%0d, all zero required",
                     acc_out, overflow, in_ready, out_valid, busy, dbg_state);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (in_ready !== 1'b0 || acc_out !== '0 || dbg_state !== 2'd0) begin
                miscompares++;
                $display("FAIL reset_ignore_valid: rdy=%b acc=%h st=%0d, required 0/00/IDLE",
                         in_ready, acc_out, dbg_state);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_nominal();
        int cyc, rdy; bit to;
        fill_const(5'h0F);
        issue_start();
        feed_samples(0, cyc, rdy, to);
        vectors++;
        if (to || rdy != N_SAMPLES || cyc != N_SAMPLES) begin
            miscompares++;
            $display("FAIL nominal_timing: timeout=%b ready_cycles=%0d cycles=%0d, required 0/%0d/%0d",
                     to, rdy, cyc, N_SAMPLES, N_SAMPLES);
        end
        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL nominal_done: ov=%b rdy=%b busy=%b, required 1/0/1", out_valid, in_ready, busy);
        end
        vectors++;
        if (acc_out !== ACC_W'(model_total()) || overflow !== (model_total() > 255)) begin
            miscompares++;
            $display("FAIL nominal_result: acc=%h ovf=%b, required %h/%b",
                     acc_out, overflow, ACC_W'(model_total()), model_total() > 255);
        end
        exp_q.push_back(ACC_W'(model_total()));
        release_result();
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || acc_out !== exp_q[$]) begin
            miscompares++;
            $display("FAIL nominal_release: ov=%b busy=%b acc=%h, required 0/0/%h",
                     out_valid, busy, acc_out, exp_q[$]);
        end
    endtask

    task automatic test_overflow_wrap();
        int cyc, rdy; bit to;
        fill_const(5'h1F);
        issue_start();
        feed_samples(0, cyc, rdy, to);
        vectors++;
        if (to || acc_out !== 8'hF0 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_wrap: timeout=%b acc=%h ovf=%b, required 0/f0/1", to, acc_out, overflow);
        end
        release_result();
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_sticky_idle: ovf=%b, required 1", overflow);
        end
        issue_start();
        vectors++;
        if (overflow !== 1'b0 || acc_out !== '0 || dbg_state !== 2'd1) begin
            miscompares++;
            $display("FAIL overflow_clear_on_start: ovf=%b acc=%h st=%0d, required 0/00/1",
                     overflow, acc_out, dbg_state);
        end
        fill_random();
        feed_samples(0, cyc, rdy, to);
        vectors++;
        if (to || acc_out !== ACC_W'(model_total()) || overflow !== (model_total() > 255)) begin
            miscompares++;
            $display("FAIL overflow_followup: timeout=%b acc=%h ovf=%b, required 0/%h/%b",
                     to, acc_out, overflow, ACC_W'(model_total()), model_total() > 255);
        end
        release_result();
    endtask

    task automatic test_bubbles();
        int cyc, rdy; bit to;
        fill_const(5'h01);
        issue_start();
        feed_samples(1, cyc, rdy, to);
        vectors++;
        if (to || cyc != 2 * N_SAMPLES - 1 || acc_out !== 8'h10 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bubbles: timeout=%b cycles=%0d acc=%h ov=%b, required 0/%0d/10/1",
                     to, cyc, acc_out, out_valid, 2 * N_SAMPLES - 1);
        end
        release_result();
    endtask

    task automatic test_backpressure();
        int cyc, rdy; bit to;
        logic [ACC_W-1:0] exp_acc;
        bit exp_ovf;
        fill_random();
        issue_start();
        feed_samples(2, cyc, rdy, to);
        exp_acc = ACC_W'(model_total());
        exp_ovf = model_total() > 255;
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL backpressure_feed: timed out after %0d cycles, required completion", cyc);
        end
        for (int i = 0; i < 10; i++) begin
            start = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            {co, s} = 5'($urandom_range(0, 31));
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || acc_out !== exp_acc || overflow !== exp_ovf) begin
                miscompares++;
                $display("FAIL backpressure_hold[%0d]: ov=%b rdy=%b acc=%h ovf=%b, required 1/0/%h/%b",
                         i, out_valid, in_ready, acc_out, overflow, exp_acc, exp_ovf);
            end
        end
        in_valid = 1'b0;
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || dbg_state !== 2'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL backpressure_release: ov=%b st=%0d busy=%b, required 0/IDLE/0",
                     out_valid, dbg_state, busy);
        end
        @(posedge clk); #1;
        vectors++;
        if (dbg_state !== 2'd0 || acc_out !== exp_acc) begin
            miscompares++;
            $display("FAIL start_with_release_ignored: st=%0d acc=%h, required IDLE/%h",
                     dbg_state, acc_out, exp_acc);
        end
        exp_q.push_back(exp_acc);
    endtask

    task automatic test_back_to_back();
        int cyc, rdy; bit to;
        logic [ACC_W-1:0] prev;
        fill_random();
        issue_start();
        feed_samples(0, cyc, rdy, to);
        prev = ACC_W'(model_total());
        release_result();
        vectors++;
        if (acc_out !== prev || dbg_state !== 2'd0) begin
            miscompares++;
            $display("FAIL b2b_retained: acc=%h st=%0d, required %h/IDLE", acc_out, dbg_state, prev);
        end
        fill_const(5'h10);
        issue_start();
        feed_samples(0, cyc, rdy, to);
        vectors++;
        if (to || acc_out !== 8'h00 || overflow !== 1'b1 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_second: timeout=%b acc=%h ovf=%b ov=%b, required 0/00/1/1",
                     to, acc_out, overflow, out_valid);
        end
        release_result();
    endtask

    task automatic test_random_bursts();
        int cyc, rdy; bit to;
        for (int b = 0; b < 6; b++) begin
            fill_random();
            issue_start();
            feed_samples(2, cyc, rdy, to);
            vectors++;
            if (to || acc_out !== ACC_W'(model_total()) || overflow !== (model_total() > 255)) begin
                miscompares++;
                $display("FAIL random_burst[%0d]: timeout=%b acc=%h ovf=%b, required 0/%h/%b",
                         b, to, acc_out, overflow, ACC_W'(model_total()), model_total() > 255);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            release_result();
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        start = 1'b0;
        s = 4'h0;
        co = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        test_reset();
        test_reset_mid_burst();
        test_nominal();
        test_overflow_wrap();
        test_bubbles();
        test_backpressure();
        test_back_to_back();
        test_random_bursts();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
